// File: rtl/user_dma_cpl_router.sv
// Completion router for user DMA reads. Snoops requests into a tag table and routes completion beats to the owning slave.
// Optional statistics counters are enabled by defining USER_DMA_CPL_STATS_EN.
module user_dma_cpl_router #(
  parameter int NUM_SLAVES = 4,
  parameter int TAG_WIDTH  = 8,
  parameter int TAG_IDX_W  = 4,
  parameter int LEN_WIDTH  = 12,
  parameter int DATA_WIDTH = 64,
  parameter int BCNT_W     = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_req_fire,
  input  logic [$clog2(NUM_SLAVES)-1:0] i_req_slave,
  input  logic [TAG_WIDTH-1:0]          i_req_tag,
  input  logic [LEN_WIDTH-1:0]          i_req_len,
  input  logic                          i_cpl_valid,
  output logic                          o_cpl_ready,
  input  logic [TAG_WIDTH-1:0]          i_cpl_tag,
  input  logic [BCNT_W-1:0]             i_cpl_bytes,
  input  logic [DATA_WIDTH-1:0]         i_cpl_data,
  output logic [NUM_SLAVES-1:0]         o_slave_data_vld,
  input  logic [NUM_SLAVES-1:0]         i_slave_data_rdy,
  output logic [DATA_WIDTH-1:0]         o_slave_data,
  output logic [TAG_WIDTH-1:0]          o_slave_tag,
  output logic [NUM_SLAVES-1:0]         o_slave_cpl_done,
  output logic                          o_err_unexp_cpl,
  output logic                          o_err_tag_reuse,
`ifdef USER_DMA_CPL_STATS_EN
  output logic [15:0]                   o_stat_done_cnt,
  output logic [15:0]                   o_stat_err_cnt,
`endif
  output logic                          o_busy
);

  localparam int SLV_W = $clog2(NUM_SLAVES);
  localparam int DEPTH = 2 ** TAG_IDX_W;
  localparam int REM_W = LEN_WIDTH + 1;

  logic [DEPTH-1:0]      tblVld_q, tblVld_d;
  logic [SLV_W-1:0]      tblSlave_q [DEPTH];
  logic [SLV_W-1:0]      tblSlave_d [DEPTH];
  logic [REM_W-1:0]      tblRem_q [DEPTH];
  logic [REM_W-1:0]      tblRem_d [DEPTH];

  logic                  outVld_q, outVld_d;
  logic [SLV_W-1:0]      outSlave_q, outSlave_d;
  logic [DATA_WIDTH-1:0] outData_q, outData_d;
  logic [TAG_WIDTH-1:0]  outTag_q, outTag_d;
  logic [NUM_SLAVES-1:0] done_q, done_d;
  logic                  errUnexp_q, errUnexp_d;
  logic                  errReuse_q, errReuse_d;
  logic                  readyEn_q;

  logic [TAG_IDX_W-1:0]  cplIdx, reqIdx;
  logic                  cplAccept, cplHit, cplFree;
  logic [REM_W-1:0]      cplBytes, cplRem, reqRem;
  logic                  unusedReqTag;

  assign cplIdx       = i_cpl_tag[TAG_IDX_W-1:0];
  assign reqIdx       = i_req_tag[TAG_IDX_W-1:0];
  assign unusedReqTag = ^i_req_tag;

  // readyEn_q keeps the completion port closed while reset is asserted
  assign o_cpl_ready = readyEn_q & (~outVld_q | i_slave_data_rdy[outSlave_q]);
  assign cplAccept   = i_cpl_valid & o_cpl_ready;
  assign cplHit      = cplAccept & tblVld_q[cplIdx];
  assign cplRem      = tblRem_q[cplIdx];
  assign cplBytes    = REM_W'(i_cpl_bytes);
  assign cplFree     = cplHit & (cplBytes >= cplRem);
  assign reqRem      = (i_req_len == '0) ? {1'b1, {LEN_WIDTH{1'b0}}} : {1'b0, i_req_len};

  // Completion retires the old entry first so a same-cycle snoop always wins
  always_comb begin
    tblVld_d   = tblVld_q;
    tblSlave_d = tblSlave_q;
    tblRem_d   = tblRem_q;
    if (cplHit) begin
      tblRem_d[cplIdx] = cplFree ? '0 : (cplRem - cplBytes);
      if (cplFree) tblVld_d[cplIdx] = 1'b0;
    end
    if (i_req_fire) begin
      tblVld_d[reqIdx]   = 1'b1;
      tblSlave_d[reqIdx] = i_req_slave;
      tblRem_d[reqIdx]   = reqRem;
    end
  end

  always_comb begin
    outVld_d   = outVld_q;
    outSlave_d = outSlave_q;
    outData_d  = outData_q;
    outTag_d   = outTag_q;
    done_d     = '0;
    if (outVld_q && i_slave_data_rdy[outSlave_q]) outVld_d = 1'b0;
    if (cplHit) begin
      outVld_d   = 1'b1;
      outSlave_d = tblSlave_q[cplIdx];
      outData_d  = i_cpl_data;
      outTag_d   = i_cpl_tag;
    end
    if (cplFree) done_d[tblSlave_q[cplIdx]] = 1'b1;
    errUnexp_d = cplAccept & ~tblVld_q[cplIdx];
    errReuse_d = i_req_fire & tblVld_q[reqIdx] & ~(cplFree && (cplIdx == reqIdx));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tblVld_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tblSlave_q[i] <= '0;
        tblRem_q[i]   <= '0;
      end
      outVld_q   <= 1'b0;
      outSlave_q <= '0;
      outData_q  <= '0;
      outTag_q   <= '0;
      done_q     <= '0;
      errUnexp_q <= 1'b0;
      errReuse_q <= 1'b0;
      readyEn_q  <= 1'b0;
    end else begin
      tblVld_q   <= tblVld_d;
      tblSlave_q <= tblSlave_d;
      tblRem_q   <= tblRem_d;
      outVld_q   <= outVld_d;
      outSlave_q <= outSlave_d;
      outData_q  <= outData_d;
      outTag_q   <= outTag_d;
      done_q     <= done_d;
      errUnexp_q <= errUnexp_d;
      errReuse_q <= errReuse_d;
      readyEn_q  <= 1'b1;
    end
  end

  always_comb begin
    o_slave_data_vld = '0;
    for (int k = 0; k < NUM_SLAVES; k++)
      o_slave_data_vld[k] = outVld_q && (outSlave_q == SLV_W'(k));
  end

  assign o_slave_data     = outData_q;
  assign o_slave_tag      = outTag_q;
  assign o_slave_cpl_done = done_q;
  assign o_err_unexp_cpl  = errUnexp_q;
  assign o_err_tag_reuse  = errReuse_q;
  assign o_busy           = |tblVld_q;

`ifdef USER_DMA_CPL_STATS_EN
  logic [15:0] statDone_q, statErr_q;

  // Counters follow the registered pulses and wrap naturally
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      statDone_q <= '0;
      statErr_q  <= '0;
    end else begin
      statDone_q <= statDone_q + 16'(|done_q);
      statErr_q  <= statErr_q + 16'(errUnexp_q) + 16'(errReuse_q);
    end
  end

  assign o_stat_done_cnt = statDone_q;
  assign o_stat_err_cnt  = statErr_q;
`endif

endmodule

// File: tb/tb_user_dma_cpl_router.sv
// Directed self-checking bench for user_dma_cpl_router (default build, stats disabled).
module tb_user_dma_cpl_router;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqFire;
  logic [1:0]  reqSlave;
  logic [7:0]  reqTag;
  logic [11:0] reqLen;
  logic        cplValid;
  logic        cplReady;
  logic [7:0]  cplTag;
  logic [3:0]  cplBytes;
  logic [63:0] cplData;
  logic [3:0]  slaveVld;
  logic [3:0]  slaveRdy;
  logic [63:0] slaveData;
  logic [7:0]  slaveTag;
  logic [3:0]  slaveDone;
  logic        errUnexp;
  logic        errReuse;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int doneHits;

  always #5 clk = ~clk;

  user_dma_cpl_router dut (
    .i_clk            (clk),
    .i_rst_n          (rstN),
    .i_req_fire       (reqFire),
    .i_req_slave      (reqSlave),
    .i_req_tag        (reqTag),
    .i_req_len        (reqLen),
    .i_cpl_valid      (cplValid),
    .o_cpl_ready      (cplReady),
    .i_cpl_tag        (cplTag),
    .i_cpl_bytes      (cplBytes),
    .i_cpl_data       (cplData),
    .o_slave_data_vld (slaveVld),
    .i_slave_data_rdy (slaveRdy),
    .o_slave_data     (slaveData),
    .o_slave_tag      (slaveTag),
    .o_slave_cpl_done (slaveDone),
    .o_err_unexp_cpl  (errUnexp),
    .o_err_tag_reuse  (errReuse),
    .o_busy           (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic fire, input logic [1:0] slv, input logic [7:0] rtag,
                               input logic [11:0] len, input logic cvld, input logic [7:0] ctag,
                               input logic [3:0] cbytes, input logic [63:0] cdata);
    reqFire  = fire;
    reqSlave = slv;
    reqTag   = rtag;
    reqLen   = len;
    cplValid = cvld;
    cplTag   = ctag;
    cplBytes = cbytes;
    cplData  = cdata;
  endtask

  task automatic applyIdle;
    applyStimulus(1'b0, 2'd0, 8'h00, 12'd0, 1'b0, 8'h00, 4'd0, 64'h0);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", name, observed, expected);
    end
  endtask

  initial begin
    rstN     = 1'b0;
    slaveRdy = 4'hF;
    applyIdle();
    #12;
    checkOutput("rst_ready", 64'(cplReady), 64'd0);
    checkOutput("rst_vld", 64'(slaveVld), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(slaveDone), 64'd0);
    rstN = 1'b1;
    tick();
    tick();
    checkOutput("post_rst_ready", 64'(cplReady), 64'd1);

    // Basic two-beat request for slave 2
    applyStimulus(1'b1, 2'd2, 8'h05, 12'd16, 1'b0, 8'h00, 4'd0, 64'h0);
    tick();
    checkOutput("snoop_busy", 64'(busy), 64'd1);
    applyStimulus(1'b0, 2'd0, 8'h00, 12'd0, 1'b1, 8'h05, 4'd8, 64'hAAAA_0000_0000_0001);
    tick();
    checkOutput("b1_vld", 64'(slaveVld), 64'h4);
    checkOutput("b1_data", slaveData, 64'hAAAA_0000_0000_0001);
    checkOutput("b1_tag", 64'(slaveTag), 64'h05);
    checkOutput("b1_done", 64'(slaveDone), 64'd0);
    applyStimulus(1'b0, 2'd0, 8'h00, 12'd0, 1'b1, 8'h05, 4'd8, 64'hBBBB_0000_0000_0002);
    tick();
    checkOutput("b2_vld", 64'(slaveVld), 64'h4);
    checkOutput("b2_data", slaveData, 64'hBBBB_0000_0000_0002);
    checkOutput("b2_done", 64'(slaveDone), 64'h4);
    checkOutput("b2_busy", 64'(busy), 64'd0);
    applyIdle();
    tick();
    checkOutput("drain_vld", 64'(slaveVld), 64'd0);
    checkOutput("drain_done", 64'(slaveDone), 64'd0);

    // Completion for a tag that was never requested
    applyStimulus(1'b0, 2'd0, 8'h00, 12'd0, 1'b1, 8'h09, 4'd8, 64'h1234);
    tick();
    checkOutput("unexp_err", 64'(errUnexp), 64'd1);
    checkOutput("unexp_vld", 64'(slaveVld), 64'd0);
    checkOutput("unexp_ready", 64'(cplReady), 64'd1);
    applyIdle();
    tick();
    checkOutput("unexp_pulse", 64'(errUnexp), 64'd0);

    // Slave 1 back-pressure for five cycles
    applyStimulus(1'b1, 2'd1, 8'h01, 12'd16, 1'b0, 8'h00, 4'd0, 64'h0);
    tick();
    slaveRdy = 4'b1101;
    applyStimulus(1'b0, 2'd0, 8'h00, 12'd0, 1'b1, 8'h01, 4'd8, 64'hC0C0_C0C0);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 12'd0, 1'b1, 8'h01, 4'd8, 64'hD0D0_D0D0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_ready", 64'(cplReady), 64'd0);
      checkOutput("stall_data", slaveData, 64'hC0C0_C0C0);
      checkOutput("stall_vld", 64'(slaveVld), 64'h2);
      tick();
    end
    slaveRdy = 4'hF;
    tick();
    checkOutput("resume_data", slaveData, 64'hD0D0_D0D0);
    checkOutput("resume_vld", 64'(slaveVld), 64'h2);
    checkOutput("resume_done", 64'(slaveDone), 64'h2);
    applyIdle();
    tick();
    checkOutput("resume_drain", 64'(slaveVld), 64'd0);

    // Zero length means 4096 bytes: 512 beats of 8
    applyStimulus(1'b1, 2'd0, 8'h03, 12'd0, 1'b0, 8'h00, 4'd0, 64'h0);
    tick();
    doneHits = 0;
    for (int i = 0; i < 511; i++) begin
      applyStimulus(1'b0, 2'd0, 8'h00, 12'd0, 1'b1, 8'h03, 4'd8, 64'(i));
      tick();
      if (slaveDone != 4'd0) doneHits++;
    end
    checkOutput("big_nodone", 64'(doneHits), 64'd0);
    checkOutput("big_busy", 64'(busy), 64'd1);
    applyStimulus(1'b0, 2'd0, 8'h00, 12'd0, 1'b1, 8'h03, 4'd8, 64'h1FF);
    tick();
    checkOutput("big_done", 64'(slaveDone), 64'h1);
    checkOutput("big_data", slaveData, 64'h1FF);
    checkOutput("big_free", 64'(busy), 64'd0);
    applyIdle();
    tick();

    // Tag reuse: second snoop overwrites length
    applyStimulus(1'b1, 2'd3, 8'h07, 12'd16, 1'b0, 8'h00, 4'd0, 64'h0);
    tick();
    checkOutput("reuse_first", 64'(errReuse), 64'd0);
    applyStimulus(1'b1, 2'd3, 8'h07, 12'd8, 1'b0, 8'h00, 4'd0, 64'h0);
    tick();
    checkOutput("reuse_flag", 64'(errReuse), 64'd1);
    applyIdle();
    tick();
    checkOutput("reuse_pulse", 64'(errReuse), 64'd0);
    applyStimulus(1'b0, 2'd0, 8'h00, 12'd0, 1'b1, 8'h07, 4'd8, 64'h77);
    tick();
    checkOutput("reuse_done", 64'(slaveDone), 64'h8);
    checkOutput("reuse_busy", 64'(busy), 64'd0);
    applyIdle();
    tick();

    // Same-cycle free and re-allocation on index 0xA
    applyStimulus(1'b1, 2'd0, 8'h0A, 12'd8, 1'b0, 8'h00, 4'd0, 64'h0);
    tick();
    applyStimulus(1'b1, 2'd1, 8'h1A, 12'd16, 1'b1, 8'h0A, 4'd8, 64'hA0);
    tick();
    checkOutput("same_done", 64'(slaveDone), 64'h1);
    checkOutput("same_noreuse", 64'(errReuse), 64'd0);
    checkOutput("same_busy", 64'(busy), 64'd1);
    checkOutput("same_vld", 64'(slaveVld), 64'h1);
    applyStimulus(1'b0, 2'd0, 8'h00, 12'd0, 1'b1, 8'h1A, 4'd8, 64'hA1);
    tick();
    checkOutput("same_b1_vld", 64'(slaveVld), 64'h2);
    checkOutput("same_b1_done", 64'(slaveDone), 64'd0);
    applyStimulus(1'b0, 2'd0, 8'h00, 12'd0, 1'b1, 8'h1A, 4'd8, 64'hA2);
    tick();
    checkOutput("same_b2_done", 64'(slaveDone), 64'h2);
    applyIdle();
    tick();

    // Beat larger than remaining bytes saturates and frees
    applyStimulus(1'b1, 2'd2, 8'h0B, 12'd4, 1'b0, 8'h00, 4'd0, 64'h0);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 12'd0, 1'b1, 8'h0B, 4'd8, 64'hB0);
    tick();
    checkOutput("under_done", 64'(slaveDone), 64'h4);
    checkOutput("under_busy", 64'(busy), 64'd0);
    applyIdle();
    tick();

    // Reset in the middle of a request
    applyStimulus(1'b1, 2'd2, 8'h05, 12'd16, 1'b0, 8'h00, 4'd0, 64'h0);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 12'd0, 1'b1, 8'h05, 4'd8, 64'h55);
    tick();
    checkOutput("mid_vld", 64'(slaveVld), 64'h4);
    applyIdle();
    rstN = 1'b0;
    #1;
    checkOutput("mid_rst_vld", 64'(slaveVld), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    tick();
    checkOutput("mid_rst_done", 64'(slaveDone), 64'd0);
    rstN = 1'b1;
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 12'd0, 1'b1, 8'h05, 4'd8, 64'h56);
    tick();
    checkOutput("mid_unexp", 64'(errUnexp), 64'd1);
    checkOutput("mid_nodone", 64'(slaveDone), 64'd0);
    checkOutput("mid_novld", 64'(slaveVld), 64'd0);
    applyIdle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
